// File: rtl/vedic_seq_mul_8x8_ctrl_if.sv
// Handshake bundle for vedic_seq_mul_8x8_ctrl.
// Operand side: in_valid/in_ready/a/b. Result side: out_valid/out_ready/res. Status: busy.
interface vedic_seq_mul_8x8_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/vedic_seq_mul_8x8_ctrl.sv
// Sequential 8x8 unsigned multiplier built around one 4x4 Vedic multiplier,
// reused over four cycles (one partial product per cycle).
// Ports: clk, rst_n (async, active-low), bus (slave modport: in_valid/in_ready/a/b,
// out_valid/out_ready/res, busy).
// Macro ACCUM_EN: when defined, res accumulates successive products mod 2^16.

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t0, x, y, z, c1;

    assign t0   = a[0] & b[0];
    assign x    = a[1] & b[0];
    assign y    = a[0] & b[1];
    assign z    = a[1] & b[1];
    assign c1   = x & y;
    assign p[0] = t0;
    assign p[1] = x ^ y;
    assign p[2] = z ^ c1;
    assign p[3] = z & c1;
endmodule

module vedic_multiplier_4x4_using_2x2 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic_2x2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_2x2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_2x2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_2x2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

    assign p = {4'b0, q0}
             + {2'b0, q1, 2'b0}
             + {2'b0, q2, 2'b0}
             + {q3, 4'b0};
endmodule

module vedic_seq_mul_8x8_ctrl (
    input  logic                            clk,
    input  logic                            rst_n,
    vedic_seq_mul_8x8_ctrl_if.slave         bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] psum;
    logic [15:0] res_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic [3:0]  na;
    logic [3:0]  nb;
    logic [7:0]  pp;
    logic [3:0]  sh;
    logic [15:0] term;
    logic [15:0] sum;

    // step bit0 picks the high nibble of a, bit1 the high nibble of b;
    // the shift is 4 per high nibble used (0, 4, 4, 8).
    assign na   = step[0] ? ra[7:4] : ra[3:0];
    assign nb   = step[1] ? rb[7:4] : rb[3:0];
    assign sh   = {step[0] & step[1], step[0] ^ step[1], 2'b00};
    assign term = {8'b0, pp} << sh;
    assign sum  = psum + term;

    vedic_multiplier_4x4_using_2x2 u_mul (
        .a (na),
        .b (nb),
        .p (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= 2'd0;
            ra          <= 8'd0;
            rb          <= 8'd0;
            psum        <= 16'd0;
            res_q       <= 16'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ra         <= bus.a;
                        rb         <= bus.b;
                        psum       <= 16'd0;
                        step       <= 2'd0;
                        state      <= MUL;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL: begin
                    psum <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
`ifdef ACCUM_EN
                        res_q       <= res_q + sum;
`else
                        res_q       <= sum;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/vedic_seq_mul_8x8_ctrl.md
VEDIC_SEQ_MUL_8X8_CTRL -- requirements
Module: vedic_seq_mul_8x8_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (8-bit operands, 16-bit result).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  res holds a completed result.
REQ-009 out_ready  input  1  consumer accepts res.
REQ-010 res  output  16  product, or accumulated sum when ACCUM_EN is defined.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL contain exactly one vedic_multiplier_4x4_using_2x2 instance and compute a*b by time-multiplexing it over four partial products.
REQ-013 FSM states SHALL be IDLE, MUL and DONE, with a 2-bit step counter used in MUL.
REQ-014 in_ready SHALL equal 1 in IDLE only; an input handshake occurs on an edge where in_valid and in_ready are both 1.
REQ-015 On the input handshake the block SHALL:
- capture a and b into internal registers;
- clear the partial-sum register;
- set step to 0;
- enter MUL.
REQ-016 In MUL, each cycle SHALL add one shifted 4x4 product into the 16-bit partial sum:
- step0: a[3:0]*b[3:0], shift 0;
- step1: a[7:4]*b[3:0], shift 4;
- step2: a[3:0]*b[7:4], shift 4;
- step3: a[7:4]*b[7:4], shift 8.
REQ-017 After the step3 edge the FSM SHALL enter DONE. out_valid SHALL go high exactly 4 clock edges after the input-handshake edge.
REQ-018 The partial sum SHALL never overflow: the maximum product is 0xFE01.
REQ-019 In DONE, out_valid=1 and res SHALL hold stable until out_ready=1. On that edge the FSM SHALL return to IDLE and drop out_valid.
REQ-020 out_valid SHALL be 0 and res SHALL hold its last completed value in IDLE and MUL.
REQ-021 in_valid, a and b SHALL be ignored while not in IDLE; captured operands are immune to input changes mid-operation.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 Back-to-back operation SHALL give a minimum of 6 cycles per result: IDLE, MUL x4, DONE with out_ready=1.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-MUL or in DONE, SHALL immediately force:
- state to IDLE;
- step, operand registers, partial sum and res to 0;
- out_valid=0, busy=0, in_ready=1.
REQ-025 An operation interrupted by reset SHALL be discarded with no output handshake; normal operation resumes on the first rising edge after rst_n=1.

Configuration
REQ-026 Macro ACCUM_EN SHALL select the result mode.
- Not defined: on entering DONE, res loads the product.
- Defined: on entering DONE, res loads (res + product) mod 2^16, wrapping silently. res is cleared only by reset.

Verification
REQ-027 a=0xFF, b=0xFF -> out_valid 4 edges after accept; res=0xFE01 (ACCUM_EN off).
REQ-028 Boundary cases:
- a=0x00, b=0xA7 -> res=0x0000;
- a=0x10, b=0x10 -> res=0x0100;
- a=0xA5, b=0x3C -> res=0x26AC.
REQ-029 Result held with out_ready=0 for 5 cycles -> res and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next edge.
REQ-030 Changing a/b and pulsing in_valid during MUL -> no effect; result matches the captured operands.
REQ-031 rst_n=0 during step2 -> outputs at reset values immediately. A new op 0x03*0x05 after release -> res=0x000F.
REQ-032 ACCUM_EN defined, sequence 0xFF*0xFF then 0x02*0x03 -> res=0xFE01, then 0xFE07.
- Further 0xFF*0xFF -> res=0xFC08 (wrap).
